// File: rtl/sd_spi_host_cmd.sv
// SD-card SPI-mode command engine: frames one command, polls for R1, collects
// optional trailing response bytes, then closes with one CS-high clocking byte.
module sd_spi_host_cmd #(
  parameter int CLK_DIV      = 4,
  parameter int PRE_BYTES    = 1,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [2:0]  resp_len,
  input  logic        crc_auto,
  output logic        done,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_ext,
  output logic        timeout,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_POLL, S_EXT, S_POST} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] PRE_LAST  = 8'(PRE_BYTES - 1);
  localparam logic [7:0] POLL_LAST = 8'(RESP_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        ready_q, done_q, timeout_q, sclk_q, cs_n_q, mosi_q;
  logic [7:0]  r1_q, div_q, cnt_q, cnt_d, tx_q, rx_q, byte_d, crcb_q, r1_p;
  logic [31:0] ext_q, arg_q, ext_p;
  logic [5:0]  idx_q;
  logic [2:0]  len_q, bit_q;
  logic        to_p, tick, rise, fall, byte_end;

  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = m[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] k, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic [7:0] crcb);
    logic [7:0] b;
    case (k)
      3'd0:    b = {2'b01, idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      default: b = crcb;
    endcase
    return b;
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign rise     = tick && !sclk_q;
  assign fall     = tick && sclk_q;
  assign byte_end = fall && (bit_q == 3'd7);

  // Byte-boundary sequencing: which state and byte come after the one just clocked.
  always_comb begin
    state_d = state_q;
    byte_d  = 8'hFF;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      S_PRE:  if (cnt_q == PRE_LAST) begin
                state_d = S_CMD;
                byte_d  = {2'b01, idx_q};
                cnt_d   = '0;
              end
      S_CMD:  if (cnt_q == 8'd5) begin
                state_d = S_POLL;
                cnt_d   = '0;
              end else byte_d = frame_byte(cnt_q[2:0] + 3'd1, idx_q, arg_q, crcb_q);
      S_POLL: if (!rx_q[7]) begin
                state_d = (len_q == 3'd0) ? S_POST : S_EXT;
                cnt_d   = '0;
              end else if (cnt_q == POLL_LAST) begin
                state_d = S_POST;
                cnt_d   = '0;
              end
      S_EXT:  if (cnt_q == 8'(len_q) - 8'd1) begin
                state_d = S_POST;
                cnt_d   = '0;
              end
      S_POST: begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;  ready_q <= 1'b0;  done_q <= 1'b0;  timeout_q <= 1'b0;
      r1_q    <= 8'hFF;   ext_q   <= '0;    sclk_q <= 1'b0;  cs_n_q    <= 1'b1;
      mosi_q  <= 1'b1;    div_q   <= '0;    bit_q  <= '0;    cnt_q     <= '0;
      tx_q    <= 8'hFF;   rx_q    <= '0;    idx_q  <= '0;    arg_q     <= '0;
      len_q   <= '0;      crcb_q  <= 8'h01; r1_p   <= 8'hFF; ext_p     <= '0;
      to_p    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        ready_q <= 1'b1;
        if (cmd_valid && ready_q) begin
          idx_q   <= cmd_index;
          arg_q   <= cmd_arg;
          len_q   <= (resp_len > 3'd4) ? 3'd4 : resp_len;
          crcb_q  <= crc_auto ? {crc7({2'b01, cmd_index, cmd_arg}), 1'b1} : 8'h01;
          ready_q <= 1'b0;
          cs_n_q  <= 1'b0;
          sclk_q  <= 1'b0;
          div_q   <= '0;
          bit_q   <= '0;
          cnt_q   <= '0;
          r1_p    <= 8'hFF;
          ext_p   <= '0;
          to_p    <= 1'b0;
          if (PRE_BYTES > 0) begin
            state_q <= S_PRE;
            tx_q    <= 8'hFF;
            mosi_q  <= 1'b1;
          end else begin
            state_q <= S_CMD;
            tx_q    <= {2'b01, cmd_index};
            mosi_q  <= 1'b0;
          end
        end
      end else begin
        if (tick) begin
          div_q  <= '0;
          sclk_q <= ~sclk_q;
        end else div_q <= div_q + 8'd1;
        if (rise) rx_q <= {rx_q[6:0], spi_miso};
        if (fall && !byte_end) begin
          bit_q  <= bit_q + 3'd1;
          tx_q   <= {tx_q[6:0], 1'b1};
          mosi_q <= tx_q[6];
        end
        if (byte_end) begin
          bit_q   <= '0;
          state_q <= state_d;
          cnt_q   <= cnt_d;
          tx_q    <= byte_d;
          mosi_q  <= byte_d[7];
          if (state_d == S_POST) cs_n_q <= 1'b1;
          case (state_q)
            S_POLL: if (!rx_q[7]) r1_p <= rx_q;
                    else if (cnt_q == POLL_LAST) to_p <= 1'b1;
            S_EXT:  ext_p[{~cnt_q[1:0], 3'b000} +: 8] <= rx_q;
            S_POST: begin
                      done_q    <= 1'b1;
                      ready_q   <= 1'b1;
                      r1_q      <= r1_p;
                      ext_q     <= ext_p;
                      timeout_q <= to_p;
                    end
            default: ;
          endcase
        end
      end
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign resp_r1   = r1_q;
  assign resp_ext  = ext_q;
  assign timeout   = timeout_q;
  assign spi_sclk  = sclk_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: doc/sd_spi_host_cmd.md
SD_SPI_HOST_CMD -- requirements
Module: sd_spi_host_cmd

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in sys_clk cycles (legal range 1..255).
REQ-002 The block SHALL have parameter PRE_BYTES, default 1, giving the number of 0xFF bytes sent with CS low before the command frame (legal range 0..15).
REQ-003 The block SHALL have parameter RESP_TIMEOUT, default 8, giving the maximum number of poll bytes allowed for R1 (legal range 1..255).
REQ-004 Port: sys_clk  in  1  single clock for all logic.
REQ-005 Port: sys_rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: cmd_valid  in  1  command request.
REQ-007 Port: cmd_ready  out  1  block idle, request accepted when cmd_valid&cmd_ready.
REQ-008 Port: cmd_index  in  6  command number, CMD0..CMD63.
REQ-009 Port: cmd_arg  in  32  command argument, sent MSB first.
REQ-010 Port: resp_len  in  3  count of extra bytes after R1: 0 for R1, 4 for R3/R7; values 5..7 are treated as 4.
REQ-011 Port: crc_auto  in  1  1 = compute CRC7; 0 = send the CRC byte as 0x01.
REQ-012 Port: done  out  1  one-cycle pulse marking transaction end.
REQ-013 Port: resp_r1  out  8  last R1 byte received, or 0xFF on timeout.
REQ-014 Port: resp_ext  out  32  extra response bytes, first byte received in bits [31:24], unused low bytes zero.
REQ-015 Port: timeout  out  1  set with done when no R1 arrived; held until next accept.
REQ-016 Port: spi_sclk  out  1  SPI clock, idle low (mode 0).
REQ-017 Port: spi_cs_n  out  1  chip select, active low.
REQ-018 Port: spi_mosi  out  1  host-to-card data, idle 1.
REQ-019 Port: spi_miso  in  1  card-to-host data (SD DAT0).

Function
REQ-020 On accept, the block SHALL latch cmd_index, cmd_arg, resp_len and crc_auto; cmd_ready SHALL go low the next cycle; input changes after accept SHALL be ignored.
REQ-021 The state sequence SHALL be IDLE -> PRE -> CMD -> POLL -> EXT -> POST -> IDLE; PRE SHALL be skipped when PRE_BYTES=0 and EXT when resp_len=0.
REQ-022 spi_cs_n SHALL fall in the cycle after accept, and the first SCLK rising edge SHALL come CLK_DIV cycles later.
REQ-023 Each bit SHALL be SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles; a byte is 16*CLK_DIV cycles, MSB first.
REQ-024 spi_mosi SHALL change only in the cycle SCLK falls, or at CS assertion for the first bit.
REQ-025 spi_miso SHALL be registered in the cycle SCLK rises.
REQ-026 PRE SHALL send PRE_BYTES bytes of 0xFF.
REQ-027 CMD SHALL send 6 bytes: {2'b01,cmd_index}, then cmd_arg[31:24], [23:16], [15:8], [7:0], then the CRC byte.
REQ-028 With crc_auto=1, the CRC byte SHALL be {crc7,1'b1}, where crc7 uses polynomial x^7+x^3+1, initial value 0, over the first 5 bytes.
REQ-029 POLL SHALL send 0xFF bytes and end at the first received byte with bit7=0, storing it in resp_r1.
REQ-030 If RESP_TIMEOUT poll bytes have no bit7=0, the block SHALL set resp_r1=0xFF, set timeout=1, and skip EXT.
REQ-031 EXT SHALL send 0xFF while receiving min(resp_len,4) bytes into resp_ext.
REQ-032 POST SHALL raise spi_cs_n, then clock one 0xFF byte with CS high.
REQ-033 After POST, done SHALL pulse for exactly one cycle and cmd_ready SHALL rise in the same cycle.
REQ-034 resp_r1, resp_ext and timeout SHALL update only at done and hold until the next done.
REQ-035 cmd_valid held high during done SHALL be accepted no earlier than the cycle after done, so every frame is separated by the POST byte.

Reset
REQ-036 While sys_rst=1, the outputs SHALL be: cmd_ready=0, done=0, timeout=0, resp_r1=0xFF, resp_ext=0, spi_sclk=0, spi_cs_n=1, spi_mosi=1, state=IDLE.
REQ-037 cmd_ready SHALL be 1 in the first cycle after sys_rst deasserts.
REQ-038 Reset mid-transaction SHALL abort with no done pulse and no glitch on spi_sclk.

Verification
REQ-039 CMD0: index 0, arg 0, crc_auto=1, card answers FF FF 01 -> MOSI FF 40 00 00 00 00 95 FF FF FF, then POST FF; resp_r1=0x01, timeout=0, one done pulse.
REQ-040 CMD8: index 8, arg 0x000001AA, resp_len=4, card answers FF 01 00 00 01 AA -> CRC byte 0x87, resp_r1=0x01, resp_ext=0x000001AA.
REQ-041 Timeout: MISO held 1, RESP_TIMEOUT=8 -> exactly 8 poll bytes, resp_r1=0xFF, timeout=1, no EXT bytes.
REQ-042 CMD55: index 55, crc_auto=0, card answers 01 -> MOSI frame 77 00 00 00 00 01; resp_ext=0.
REQ-043 Reset during CMD byte 3 -> outputs at reset values the same cycle; a new CMD0 after release completes normally.
REQ-044 Back-to-back: cmd_valid held high through two commands -> CS high for one full POST byte between frames; SCLK period 2*CLK_DIV cycles everywhere.
